// File: rtl/lpm_inpad_filter_pkg.sv
// Shared constants and helpers for the pad input filter: legal parameter
// ranges, counter sizing and the per-bit edge pulse record.
package lpm_inpad_filter_pkg;

    localparam int SYNC_MIN   = 2;
    localparam int SYNC_MAX   = 3;
    localparam int FILTER_MIN = 1;
    localparam int FILTER_MAX = 256;

    typedef struct packed {
        logic rise;
        logic fall;
    } edge_t;

    function automatic int clog2(input int v);
        int r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    // A filter of 1 still needs a 1-bit counter so the port widths stay legal.
    function automatic int cnt_w(input int filter);
        return (clog2(filter) < 1) ? 1 : clog2(filter);
    endfunction

endpackage

// File: rtl/lpm_inpad_filter_bit.sv
// One pad bit: metastability synchronizer, qualification counter, filtered
// level and registered one-cycle rise/fall pulses.
module lpm_inpad_filter_bit
    import lpm_inpad_filter_pkg::*;
#(
    parameter int   SYNC_STAGES = 2,
    parameter int   FILTER      = 4,
    parameter logic AVALUE      = 1'b0
) (
    input  logic  clock,
    input  logic  aclr,
    input  logic  pad,
    input  logic  clken,
    output logic  result,
    output edge_t edg
);

    localparam int             CW       = cnt_w(FILTER);
    localparam logic [CW-1:0]  CNT_LAST = CW'(FILTER - 1);

    logic [SYNC_STAGES-1:0] sync_pipe;
    logic [CW-1:0]          cnt;
    logic                   sync;

    assign sync = sync_pipe[SYNC_STAGES-1];

    always_ff @(posedge clock or posedge aclr) begin
        if (aclr) begin
            sync_pipe <= {SYNC_STAGES{AVALUE}};
            result    <= AVALUE;
            cnt       <= '0;
            edg       <= '0;
        end else begin
            sync_pipe <= {sync_pipe[SYNC_STAGES-2:0], pad};
            edg       <= '0;
            // Any agreement restarts qualification; clken only gates progress.
            if (sync == result) begin
                cnt <= '0;
            end else if (clken) begin
                if (cnt == CNT_LAST) begin
                    result   <= sync;
                    cnt      <= '0;
                    edg.rise <= sync;
                    edg.fall <= ~sync;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/lpm_inpad_filter.sv
// Debounced, synchronized multi-bit pad input with per-bit edge pulses and
// a combined change flag.
module lpm_inpad_filter
    import lpm_inpad_filter_pkg::*;
#(
    parameter                        lpm_type        = "lpm_inpad_filter",
    parameter int                    lpm_width       = 1,
    parameter int                    lpm_sync_stages = 2,
    parameter int                    lpm_filter      = 4,
    parameter logic [lpm_width-1:0]  lpm_avalue      = '0,
    parameter                        lpm_hint        = "UNUSED"
) (
    input  logic                 clock,
    input  logic                 aclr,
    input  logic [lpm_width-1:0] pad,
    input  logic                 clken,
    output logic [lpm_width-1:0] result,
    output logic [lpm_width-1:0] rise,
    output logic [lpm_width-1:0] fall,
    output logic                 changed
);

    if (lpm_width < 1) begin : g_bad_width
        $error("lpm_width must be >= 1");
    end
    if (lpm_sync_stages < SYNC_MIN || lpm_sync_stages > SYNC_MAX) begin : g_bad_sync
        $error("lpm_sync_stages out of range 2..3");
    end
    if (lpm_filter < FILTER_MIN || lpm_filter > FILTER_MAX) begin : g_bad_filter
        $error("lpm_filter out of range 1..256");
    end
    if (lpm_type != "lpm_inpad_filter") begin : g_bad_type
        $error("lpm_type must be lpm_inpad_filter");
    end
    if ($bits(lpm_hint) < 8) begin : g_bad_hint
        $error("lpm_hint must be a non-empty string");
    end

    edge_t [lpm_width-1:0] edg;

    for (genvar i = 0; i < lpm_width; i++) begin : g_bit
        lpm_inpad_filter_bit #(
            .SYNC_STAGES (lpm_sync_stages),
            .FILTER      (lpm_filter),
            .AVALUE      (lpm_avalue[i])
        ) u_bit (
            .clock  (clock),
            .aclr   (aclr),
            .pad    (pad[i]),
            .clken  (clken),
            .result (result[i]),
            .edg    (edg[i])
        );
        assign rise[i] = edg[i].rise;
        assign fall[i] = edg[i].fall;
    end

    assign changed = |{rise, fall};

endmodule

// File: tb/tb_lpm_inpad_filter.sv
// Scoreboard bench for lpm_inpad_filter across three parameterizations.
module tb_lpm_inpad_filter;

    typedef struct packed {
        logic [3:0] result;
        logic [3:0] rise;
        logic [3:0] fall;
        logic       changed;
    } exp_t;

    logic clock;
    logic aclr0, pad0, clken0, res0, rise0, fall0, chg0;
    logic aclr1, clken1, chg1;
    logic [3:0] pad1, res1, rise1, fall1;
    logic aclr2, pad2, clken2, res2, rise2, fall2, chg2;

    int   n_chk  = 0;
    int   n_fail = 0;
    exp_t sbq[$];

    lpm_inpad_filter u_dut0 (
        .clock(clock), .aclr(aclr0), .pad(pad0), .clken(clken0),
        .result(res0), .rise(rise0), .fall(fall0), .changed(chg0)
    );

    lpm_inpad_filter #(.lpm_width(4), .lpm_avalue(4'hF)) u_dut1 (
        .clock(clock), .aclr(aclr1), .pad(pad1), .clken(clken1),
        .result(res1), .rise(rise1), .fall(fall1), .changed(chg1)
    );

    lpm_inpad_filter #(.lpm_filter(1), .lpm_sync_stages(3)) u_dut2 (
        .clock(clock), .aclr(aclr2), .pad(pad2), .clken(clken2),
        .result(res2), .rise(rise2), .fall(fall2), .changed(chg2)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t observe(input int d);
        exp_t o;
        case (d)
            0:       o = '{result: {3'b0, res0}, rise: {3'b0, rise0}, fall: {3'b0, fall0}, changed: chg0};
            1:       o = '{result: res1, rise: rise1, fall: fall1, changed: chg1};
            default: o = '{result: {3'b0, res2}, rise: {3'b0, rise2}, fall: {3'b0, fall2}, changed: chg2};
        endcase
        return o;
    endfunction

    task automatic check_all(input string tag, input exp_t o, input exp_t e);
        chk({tag, ".result"},  o.result, e.result);
        chk({tag, ".rise"},    o.rise,   e.rise);
        chk({tag, ".fall"},    o.fall,   e.fall);
        chk({tag, ".changed"}, {3'b0, o.changed}, {3'b0, e.changed});
    endtask

    // Drive inputs for the coming edge, queue what the outputs must be after it.
    task automatic edge_step(input int d, input logic a, input logic [3:0] p, input logic ce,
                             input logic [3:0] r, input logic [3:0] ri, input logic [3:0] fa,
                             input string tag);
        exp_t e;
        case (d)
            0:       begin aclr0 = a; pad0 = p[0]; clken0 = ce; end
            1:       begin aclr1 = a; pad1 = p;    clken1 = ce; end
            default: begin aclr2 = a; pad2 = p[0]; clken2 = ce; end
        endcase
        sbq.push_back('{result: r, rise: ri, fall: fa, changed: |{ri, fa}});
        @(posedge clock);
        #1;
        e = sbq.pop_front();
        check_all(tag, observe(d), e);
    endtask

    task automatic do_reset(input int d, input logic [3:0] av, input string tag);
        case (d)
            0:       begin aclr0 = 1'b1; pad0 = av[0]; end
            1:       begin aclr1 = 1'b1; pad1 = av;    end
            default: begin aclr2 = 1'b1; pad2 = av[0]; end
        endcase
        @(negedge clock);
        check_all(tag, observe(d), '{result: av, rise: 4'h0, fall: 4'h0, changed: 1'b0});
    endtask

    function automatic logic padv38(input int n);
        if (n < 1 || n > 32) return 1'b0;
        return (((n - 1) / 8) % 2) == 0;
    endfunction

    initial begin
        aclr0 = 1'b1; pad0 = 1'b0; clken0 = 1'b1;
        aclr1 = 1'b1; pad1 = 4'hF; clken1 = 1'b1;
        aclr2 = 1'b1; pad2 = 1'b0; clken2 = 1'b1;
        #2;
        check_all("rst0_preclk", observe(0), '{result: 4'h0, rise: 4'h0, fall: 4'h0, changed: 1'b0});
        check_all("rst1_preclk", observe(1), '{result: 4'hF, rise: 4'h0, fall: 4'h0, changed: 1'b0});

        // Step accepted on edge 6 after release.
        do_reset(0, 4'h0, "t033_rst");
        for (int k = 1; k <= 7; k++)
            edge_step(0, 1'b0, 4'h1, 1'b1, 4'(k >= 6), 4'(k == 6), 4'h0, $sformatf("t033_e%0d", k));

        // Asynchronous clear pulls result back without a clock edge.
        aclr0 = 1'b1;
        #1;
        chk("async_clr.result", {3'b0, res0}, 4'h0);

        // Three-clock glitch is rejected.
        do_reset(0, 4'h0, "t034_rst");
        for (int k = 1; k <= 10; k++)
            edge_step(0, 1'b0, 4'(k <= 3), 1'b1, 4'h0, 4'h0, 4'h0, $sformatf("t034_e%0d", k));

        // One-edge dropout restarts qualification from zero.
        do_reset(0, 4'h0, "t024_rst");
        for (int k = 1; k <= 11; k++)
            edge_step(0, 1'b0, 4'(k <= 3 || k >= 5), 1'b1, 4'(k >= 10), 4'(k == 10), 4'h0,
                      $sformatf("t024_e%0d", k));

        // clken low on the second qualifying edge delays acceptance by one.
        do_reset(0, 4'h0, "t035_rst");
        for (int k = 1; k <= 8; k++)
            edge_step(0, 1'b0, 4'h1, (k != 4), 4'(k >= 7), 4'(k == 7), 4'h0, $sformatf("t035_e%0d", k));

        // Reset on qualifying edge 3 discards progress.
        do_reset(0, 4'h0, "t037_rst");
        for (int k = 1; k <= 4; k++)
            edge_step(0, 1'b0, 4'h1, 1'b1, 4'h0, 4'h0, 4'h0, $sformatf("t037_pre%0d", k));
        edge_step(0, 1'b1, 4'h1, 1'b1, 4'h0, 4'h0, 4'h0, "t037_clr");
        for (int k = 1; k <= 7; k++)
            edge_step(0, 1'b0, 4'h1, 1'b1, 4'(k >= 6), 4'(k == 6), 4'h0, $sformatf("t037_e%0d", k));

        // Multi-bit falls from an all-ones reset value.
        do_reset(1, 4'hF, "t036_rst");
        for (int k = 1; k <= 7; k++)
            edge_step(1, 1'b0, 4'h5, 1'b1, (k >= 6) ? 4'h5 : 4'hF, 4'h0, (k == 6) ? 4'hA : 4'h0,
                      $sformatf("t036_e%0d", k));

        // filter=1, three sync stages: each toggle lands 4 edges after sampling.
        do_reset(2, 4'h0, "t038_rst");
        for (int n = 1; n <= 36; n++) begin
            logic r, rp;
            r  = padv38(n - 3);
            rp = padv38(n - 4);
            edge_step(2, 1'b0, {3'b0, padv38(n)}, 1'b1, {3'b0, r}, {3'b0, r & ~rp}, {3'b0, ~r & rp},
                      $sformatf("t038_e%0d", n));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/lpm_inpad_filter.md
LPM_INPAD_FILTER -- requirements
Module: lpm_inpad_filter

Interface
REQ-001 lpm_type, default "lpm_inpad_filter", LPM type identifier string.
REQ-002 lpm_width, default 1, number of pad bits (>=1).
REQ-003 lpm_sync_stages, default 2, synchronizer depth (legal 2..3).
REQ-004 lpm_filter, default 4, consecutive qualifying clocks before a level change is accepted (legal 1..256).
REQ-005 lpm_avalue, default 0, value of synchronizer and result registers while aclr is asserted.
REQ-006 lpm_hint, default "UNUSED", vendor hint string; no functional effect.
REQ-007 clock  input  1  rising-edge clock; the block's only clock.
REQ-008 aclr  input  1  reset, asynchronous, active-high.
REQ-009 pad  input  lpm_width  asynchronous off-chip level.
REQ-010 clken  input  1  qualifies filter counting; the synchronizer runs regardless.
REQ-011 result  output  lpm_width  filtered, synchronized level.
REQ-012 rise  output  lpm_width  one-clock pulse per bit on an accepted 0->1 change of result.
REQ-013 fall  output  lpm_width  one-clock pulse per bit on an accepted 1->0 change of result.
REQ-014 changed  output  1  OR of all rise and fall bits, same cycle.

Function
REQ-015 Each bit SHALL pass through lpm_sync_stages flops clocked every edge; the last stage is sync[i].
REQ-016 Each bit SHALL own a counter cnt[i] of width max(1, clog2(lpm_filter)).
REQ-017 If sync[i]==result[i] at an edge: cnt[i] SHALL clear to 0; rise[i]/fall[i] SHALL be 0.
REQ-018 If sync[i]!=result[i], clken=1, and cnt[i]<lpm_filter-1: cnt[i] SHALL increment by 1.
REQ-019 If sync[i]!=result[i], clken=1, and cnt[i]==lpm_filter-1: result[i] SHALL take sync[i], cnt[i] SHALL clear, and rise[i] or fall[i] SHALL pulse high for exactly that cycle.
REQ-020 If sync[i]!=result[i] and clken=0: cnt[i] SHALL hold; there SHALL be no update and no pulse.
REQ-021 The counter SHALL never wrap: it is bounded by REQ-019.
REQ-022 Latency, clken=1: a pad step held stable SHALL reach result on edge lpm_sync_stages+lpm_filter after the first sampling edge.
REQ-023 A glitch shorter than lpm_filter synced cycles SHALL produce no change on result, rise, or fall.
REQ-024 Any return to agreement during counting SHALL restart qualification from 0 (no accumulation).
REQ-025 Bits SHALL be fully independent; simultaneous accepted changes on several bits SHALL raise all their pulses in the same cycle.
REQ-026 rise[i] and fall[i] SHALL never both be high.

Reset
REQ-027 While aclr=1: sync stages=lpm_avalue, result=lpm_avalue, cnt=0, rise=0, fall=0, changed=0, independent of clock.
REQ-028 On aclr deassertion, qualification SHALL start from cnt=0; a pad level differing from lpm_avalue SHALL be accepted after the REQ-022 latency.
REQ-029 aclr asserted mid-qualification SHALL discard progress; no pulse SHALL be emitted for that change.

Structure
REQ-030 A shared package SHALL hold the clog2 helper and the legal-range constants for lpm_sync_stages and lpm_filter.
REQ-031 One per-bit sub-module, lpm_inpad_filter_bit (synchronizer, counter, result bit, edge pulses), SHALL be instantiated lpm_width times; the top SHALL form changed.
REQ-032 Illegal parameter values SHALL be flagged at elaboration.

Verification
REQ-033 Defaults, aclr pulse, pad=1 from the first post-reset edge, clken=1 -> result=1 and rise=1 on edge 6; result=0 and rise=0 before it.
REQ-034 lpm_filter=4, pad high for 3 clocks then low -> result stays 0; rise, fall, and changed stay 0 throughout.
REQ-035 lpm_filter=4, pad rises, clken=0 on the 2nd qualifying edge -> result rises one edge later than in REQ-033 (edge 7).
REQ-036 lpm_width=4, lpm_avalue=4'hF, pad=4'h5 -> fall=4'hA for exactly one cycle; changed=1 that cycle; result=4'h5.
REQ-037 aclr asserted for one cycle at qualifying edge 3 -> result=lpm_avalue immediately; no pulse; acceptance occurs 6 edges after release.
REQ-038 lpm_filter=1, lpm_sync_stages=3, pad toggles every 8 clocks -> each toggle appears on result 4 edges later, with alternating rise/fall pulses.
